// File: rtl/iob_ext_mem_arbiter.sv
// iob_ext_mem_arbiter: shares one external memory controller port between an
// instruction master (i_*) and a data master (d_*). One transaction is
// outstanding at a time. Arbitration takes one cycle. Request and ready
// signals then pass combinationally from the granted master to the slave.
//
// Ports
//   clk_i, arst_n_i      clock, asynchronous active-low reset
//   i_* / d_*            master request (valid/addr/wdata/wstrb) and response
//                        (rdata/rvalid/ready); wstrb != 0 means write
//   m_*                  slave side toward the external memory controller
//   grant_o              one-hot owner: bit0 instruction, bit1 data, 0 idle
//
// Configuration
//   IOB_EXT_MEM_ARB_RR_EN  defined: round-robin between masters.
//                          undefined: fixed priority, where the data master wins.
module iob_ext_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  i_valid_i,
  input  logic [ADDR_W-1:0]     i_addr_i,
  input  logic [DATA_W-1:0]     i_wdata_i,
  input  logic [DATA_W/8-1:0]   i_wstrb_i,
  output logic [DATA_W-1:0]     i_rdata_o,
  output logic                  i_rvalid_o,
  output logic                  i_ready_o,
  input  logic                  d_valid_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  input  logic [DATA_W/8-1:0]   d_wstrb_i,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  d_rvalid_o,
  output logic                  d_ready_o,
  output logic                  m_valid_o,
  output logic [ADDR_W-1:0]     m_addr_o,
  output logic [DATA_W-1:0]     m_wdata_o,
  output logic [DATA_W/8-1:0]   m_wstrb_o,
  input  logic [DATA_W-1:0]     m_rdata_i,
  input  logic                  m_rvalid_i,
  input  logic                  m_ready_i,
  output logic [1:0]            grant_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        pick_d_c;

  // Mux for the currently granted master: data when grant bit1 is set.
  logic              sel_d;
  logic              sel_valid;
  logic [STRB_W-1:0] sel_wstrb;

  assign sel_d     = grant_q[1];
  assign sel_valid = sel_d ? d_valid_i : i_valid_i;
  assign sel_wstrb = sel_d ? d_wstrb_i : i_wstrb_i;

`ifdef IOB_EXT_MEM_ARB_RR_EN
  // ptr_q: 1 = data served last, 0 = instruction served last.
  logic ptr_q, ptr_d;
  // If both masters request, grant the one that was not served last.
  assign pick_d_c = d_valid_i & (~i_valid_i | ~ptr_q);
`else
  assign pick_d_c = d_valid_i;
`endif

  // Next-state, grant and pointer logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef IOB_EXT_MEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid_i || d_valid_i) begin
          state_d = GRANT;
          grant_d = pick_d_c ? 2'b10 : 2'b01;
`ifdef IOB_EXT_MEM_ARB_RR_EN
          ptr_d   = pick_d_c;
`endif
        end
      end
      GRANT: begin
        if (!sel_valid) begin
          // The master withdrew before acceptance. Nothing reached the slave.
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (m_ready_i) begin
          if (|sel_wstrb) begin
            state_d = IDLE;
            grant_d = 2'b00;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (m_rvalid_i) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
`ifdef IOB_EXT_MEM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef IOB_EXT_MEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Request and ready pass-through, open only in GRANT.
  logic in_grant_c, in_wait_c;
  assign in_grant_c = (state_q == GRANT);
  assign in_wait_c  = (state_q == WAIT_RD);

  assign m_valid_o = in_grant_c & sel_valid;
  assign m_addr_o  = sel_d ? d_addr_i  : i_addr_i;
  assign m_wdata_o = sel_d ? d_wdata_i : i_wdata_i;
  assign m_wstrb_o = sel_wstrb;

  assign i_ready_o = in_grant_c & grant_q[0] & m_ready_i;
  assign d_ready_o = in_grant_c & grant_q[1] & m_ready_i;

  // Responses are forwarded only to the owner, and only in WAIT_RD.
  // A spurious rvalid in any other state is dropped.
  assign i_rvalid_o = in_wait_c & grant_q[0] & m_rvalid_i;
  assign d_rvalid_o = in_wait_c & grant_q[1] & m_rvalid_i;
  assign i_rdata_o  = m_rdata_i;
  assign d_rdata_o  = m_rdata_i;

  assign grant_o = grant_q;

endmodule
